// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link (transmit and receive sides).
// Field order on the link: field 0 sits in the least significant DATA_W bits
// of a packed message and is sent first.
package interboard_pkg;

    localparam int DEF_DATA_W = 6;
    localparam int DEF_FIELDS = 6;

    // All-ones word driven while the other board holds us in reset
    localparam logic [63:0] RESET_TOKEN = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_REQ   = 2'd2,
        ST_ACKD  = 2'd3
    } link_state_e;

    // Bit offset of field k inside a packed message
    function automatic int field_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Message FIFO: DEPTH entries of WIDTH bits, with synchronous clear.
// A push while full is dropped; fullness is judged before any same-cycle pop.
module msg_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/interboard_tx_queue.sv
// Inter-board transmitter: queues whole messages from GameControl and sends
// them field by field over a 4-phase Request/Ack link.
// Optional build macro ACK_TIMEOUT_EN adds a per-edge Ack timeout and the
// err_timeout port; without it the link waits on Ack indefinitely.
module interboard_tx_queue
    import interboard_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FIELDS  = DEF_FIELDS,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       interboard_rst,
    input  logic                       ctrl_en,
    input  logic [FIELDS*DATA_W-1:0]   ctrl_fields,
    input  logic                       Ack_in,
    output logic                       ctrl_full,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic                       pkt_done,
    output logic                       Request_out,
    output logic [DATA_W-1:0]          inter_data_out
`ifdef ACK_TIMEOUT_EN
    ,
    output logic                       err_timeout
`endif
);
    localparam int MSG_W = FIELDS * DATA_W;
    localparam int IDX_W = (FIELDS > 1) ? $clog2(FIELDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIELDS - 1);

    logic              ack_meta_q, ack_s_q;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [MSG_W-1:0]  fifo_rd;
    logic              timed_out;

    link_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pkt_done_q, pkt_done_d;
    logic              overflow_q, overflow_d;
    logic              err_d;

    msg_fifo #(.WIDTH(MSG_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (interboard_rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (ctrl_fields),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ctrl_full      = fifo_full;
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow       = overflow_q;
    assign pkt_done       = pkt_done_q;
    assign Request_out    = req_q;
    assign inter_data_out = data_q;

    // Two-flop synchroniser for the asynchronous Ack from the other board
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= Ack_in;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Handshake FSM next state; data is loaded one cycle ahead of Request
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        msg_d      = msg_q;
        req_d      = req_q;
        data_d     = data_q;
        pkt_done_d = 1'b0;
        err_d      = 1'b0;
        fifo_pop   = 1'b0;
        fifo_push  = ctrl_en && !interboard_rst && !fifo_full;
        overflow_d = ctrl_en && !interboard_rst && fifo_full;
        if (interboard_rst) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            req_d   = 1'b0;
            data_d  = RESET_TOKEN[DATA_W-1:0];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_rd[field_lsb(0, DATA_W) +: DATA_W];
                        msg_d    = fifo_rd >> DATA_W;
                        idx_d    = '0;
                        state_d  = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (ack_s_q) begin
                        req_d   = 1'b0;
                        state_d = ST_ACKD;
                    end else if (timed_out) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ACKD: begin
                    if (!ack_s_q) begin
                        if (idx_q == LAST_IDX) begin
                            pkt_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            data_d  = msg_q[DATA_W-1:0];
                            msg_d   = msg_q >> DATA_W;
                            state_d = ST_SETUP;
                        end
                    end else if (timed_out) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and registered link outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            msg_q      <= '0;
            req_q      <= 1'b0;
            data_q     <= '0;
            pkt_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            msg_q      <= msg_d;
            req_q      <= req_d;
            data_q     <= data_d;
            pkt_done_q <= pkt_done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ACK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q;

    assign timed_out   = (timer_q == TMR_W'(TIMEOUT - 1));
    assign err_timeout = err_q;

    // Per-edge wait counter: restarts on every state change
    always_comb begin
        timer_d = '0;
        if (state_d == state_q && (state_q == ST_REQ || state_q == ST_ACKD))
            timer_d = timer_q + TMR_W'(1);
    end

    // Timeout counter and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end
`else
    logic unused_cfg;

    assign timed_out  = 1'b0;
    assign unused_cfg = err_d ^ (TIMEOUT > 0);
`endif

endmodule

// File: doc/interboard_tx_queue.md
# interboard_tx_queue

Parametrised inter-board transmitter and successor to the single-message sender. It accepts whole multi-field messages from GameControl into a small FIFO, so bursts are not lost. It then serialises each message field-by-field over the 4-phase Request/Ack link to the other board. It sits between GameControl and the board-to-board header pins, opposite the receive side.

## Interface
- DATA_W, default 6: width of one link word / field.
- FIELDS, default 6: fields per message; field 0 is sent first.
- DEPTH, default 4: message FIFO depth; power of two, at least 2.
- TIMEOUT, default 1_000_000: cycles to wait per handshake edge (used only with the macro).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- interboard_rst  in  1  reset issued by the other board; synchronous clear.
- ctrl_en  in  1  one-cycle push strobe from GameControl.
- ctrl_fields  in  FIELDS*DATA_W  packed message; field k is bits [k*DATA_W +: DATA_W]. Narrower fields are zero-extended by the caller.
- Ack_in  in  1  Ack from the other board; asynchronous.
- ctrl_full  out  1  FIFO holds DEPTH messages.
- busy  out  1  FSM is not in IDLE, or the FIFO is non-empty.
- fifo_count  out  $clog2(DEPTH+1)  messages queued, excluding the one in flight.
- overflow  out  1  one-cycle pulse when ctrl_en is dropped.
- pkt_done  out  1  one-cycle pulse when the last field's handshake completes.
- Request_out  out  1  Request to the other board.
- inter_data_out  out  DATA_W  link data.
- err_timeout  out  1  one-cycle pulse on an aborted message; present only with ACK_TIMEOUT_EN.

## Operation
- **Ack synchronisation:** Ack_in passes through a 2-flop synchroniser to give ack_s. All handshake decisions use ack_s.
- **Push:**
  - ctrl_en with count < DEPTH writes ctrl_fields to the FIFO.
  - ctrl_en with count == DEPTH drops the message and pulses overflow.
  - Fullness is judged on count before any same-cycle pop.
- **FSM states:** IDLE, SETUP, REQ, ACKD.
  - IDLE: if the FIFO is non-empty, pop it into the shift register, set idx=0 and go to SETUP.
  - SETUP: inter_data_out = field[idx]; Request_out=0; lasts exactly 1 cycle; go to REQ.
  - REQ: Request_out=1 and data held; move to ACKD when ack_s=1.
  - ACKD: Request_out=0 and data held; when ack_s=0, either:
    - if idx==FIELDS-1, pulse pkt_done and go to IDLE;
    - otherwise increment idx and go to SETUP.
- **idx counter:** width $clog2(FIELDS), no wrap past FIELDS-1.
- **Outputs:** Request_out and inter_data_out are registered, with no combinational path from inputs.
- **interboard_rst high:**
  - FSM returns to IDLE, FIFO empties, Request_out=0.
  - inter_data_out = all ones (reset token), held while interboard_rst is high.
  - ctrl_en in that cycle is ignored, with no overflow pulse.
- **rst:** clears everything immediately, including mid-handshake. Output values:
  - Request_out=0
  - inter_data_out=0
  - fifo_count=0
  - ctrl_full=0
  - busy=0
  - overflow=0
  - pkt_done=0
  - err_timeout=0

## Timing
- Push to first Request rise with an empty FIFO and IDLE FSM:
  - ctrl_en in cycle 0;
  - pop in cycle 1;
  - SETUP in cycle 2;
  - Request_out=1 in cycle 3.
- Data is valid at least 1 cycle before Request rises and is stable until Request falls.
- Ack latency is 2 cycles of synchroniser delay per edge.
- Per field, with an ideal partner: 1 SETUP cycle + (2 + partner delay) in REQ + (2 + partner delay) in ACKD.
- Back-to-back messages incur 1 IDLE cycle between pkt_done and the next SETUP.
- fifo_count and ctrl_full update the cycle after push or pop. A push and pop in the same cycle leave the count unchanged.

## Configuration
- ACK_TIMEOUT_EN defined:
  - A counter runs in REQ and in ACKD and clears on each state entry.
  - On reaching TIMEOUT-1, Request_out goes to 0 and the rest of the message is discarded.
  - err_timeout pulses and the FSM goes to IDLE. The next message then starts normally.
- Not defined: there is no counter and no err_timeout port, and the FSM waits on Ack indefinitely.

## Structure
- Shared package interboard_pkg holds:
  - the state enum;
  - the reset token constant (all ones);
  - defaults for DATA_W and FIELDS;
  - the field-order convention, shared with the receive side.
- Sub-module msg_fifo holds the parametrised width FIELDS*DATA_W and DEPTH, with push, pop, count, full and empty. It is reused by the receive side.
- The synchroniser is inline, with 2 flops.

## Test plan
- **Single message:** ctrl_fields={6'd1,6'd0,6'd4,6'd17,6'd3,6'd2} pushed, with an auto-Ack partner at 3-cycle delay.
  - Required: link words 2,3,17,4,0,1 in that order, 6 handshakes, pkt_done once, busy low afterwards.
- **Burst overflow, DEPTH=4:** 6 ctrl_en pulses on consecutive cycles while the partner stalls Ack.
  - Required: first message in flight, 4 queued, ctrl_full=1, overflow pulses once on the 6th push.
  - After Ack resumes: exactly 5 pkt_done pulses, in FIFO order.
- **Setup rule:** on every Request rise, inter_data_out equals its value in the previous cycle and does not change until Request falls.
- **interboard_rst during REQ of field 2:**
  - Required next cycle: Request_out=0, inter_data_out=6'h3F, fifo_count=0.
  - After release: no residual fields are sent.
- **Async rst mid-ACKD:** all outputs reach their reset values without a clock edge; a new push afterwards transmits normally.
- **ACK_TIMEOUT_EN with TIMEOUT=50, partner never acks:**
  - Required: Request falls after 50 REQ cycles, err_timeout pulses, and the queued second message then starts SETUP.
